// File: rtl/prog_loader.sv
// Program loader: holds a program image in RAM, streams it over sclk/mosi/mode into the
// target core, then runs it until done_in or timeout. Define PROG_LOADER_CRC_EN to add crc_out.
module prog_loader #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int LANES   = 1,
    parameter int CLK_DIV = 2,
    parameter int RST_CYC = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   len_in,
    input  logic              start,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic              sclk_out,
    output logic              rst_n_out,
    output logic [LANES-1:0]  mosi_out,
    output logic [1:0]        mode_out,
    input  logic              done_in
`ifdef PROG_LOADER_CRC_EN
    ,
    output logic [7:0]        crc_out
`endif
);

    localparam int BPW   = DATA_W / LANES;
    localparam int BIT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(BPW - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [RST_W-1:0] RST_MAX = RST_W'(RST_CYC - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_TRST, S_LOAD, S_RUN, S_ERR} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                finished_q, finished_d;
    logic                error_q, error_d;
    logic                sclk_q, sclk_d;
    logic                rst_n_q, rst_n_d;
    logic [LANES-1:0]    mosi_q, mosi_d;
    logic [1:0]          mode_q, mode_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [TO_W-1:0]     run_cnt_q, run_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic [2:0]          done_sync_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                start_ok, tick, sclk_fall, done_rise, mem_we;
    logic                present;
    logic [DATA_W-1:0]   nxt_word;

`ifdef PROG_LOADER_CRC_EN
    logic [7:0]          crc_q, crc_d;

    // CRC-8, poly 0x07, fed with the lanes of one sclk period, highest lane first
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [LANES-1:0] bits);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = LANES - 1; i >= 0; i--) begin
            fb = c[7] ^ bits[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    assign start_ok  = start && !busy_q;
    assign tick      = (div_cnt_q == DIV_MAX);
    assign sclk_fall = tick && sclk_q;
    assign done_rise = done_sync_q[1] && !done_sync_q[2];
    assign mem_we    = wr_en && !busy_q && !start;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        finished_d = 1'b0;
        error_d    = error_q;
        sclk_d     = sclk_q;
        rst_n_d    = rst_n_q;
        mosi_d     = mosi_q;
        mode_d     = mode_q;
        div_cnt_d  = div_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        rd_addr_d  = rd_addr_q;
        run_cnt_d  = run_cnt_q;
        shift_d    = shift_q;
        present    = 1'b0;
        nxt_word   = '0;
`ifdef PROG_LOADER_CRC_EN
        crc_d      = crc_q;
`endif

        if (state_q == S_TRST || state_q == S_LOAD || state_q == S_RUN) begin
            if (tick) begin
                div_cnt_d = '0;
                sclk_d    = !sclk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        case (state_q)
            S_IDLE, S_ERR: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                sclk_d    = 1'b0;
                div_cnt_d = '0;
                rst_n_d   = 1'b0;
                mosi_d    = '0;
                mode_d    = MODE_IDLE;
                if (start_ok) begin
                    state_d   = S_TRST;
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                    len_d     = (len_in > DEPTH_L) ? DEPTH_L : len_in;
                    rst_cnt_d = '0;
                    rd_addr_d = '0;
`ifdef PROG_LOADER_CRC_EN
                    crc_d     = 8'h00;
`endif
                end
            end
            S_TRST: begin
                if (sclk_fall) begin
                    if (rst_cnt_q == RST_MAX) begin
                        rst_n_d = 1'b1;
                        if (len_q == '0) begin
                            state_d   = S_RUN;
                            mode_d    = MODE_RUN;
                            run_cnt_d = '0;
                        end else begin
                            // rd_data_q has held word 0 since the start cycle
                            state_d    = S_LOAD;
                            mode_d     = MODE_LOAD;
                            present    = 1'b1;
                            nxt_word   = rd_data_q;
                            bit_cnt_d  = '0;
                            word_cnt_d = '0;
                            rd_addr_d  = ADDR_W'(1);
                        end
                    end else begin
                        rst_cnt_d = rst_cnt_q + RST_W'(1);
                    end
                end
            end
            S_LOAD: begin
                if (sclk_fall) begin
                    if (bit_cnt_q == BIT_MAX) begin
                        if (word_cnt_q == len_q - (ADDR_W + 1)'(1)) begin
                            state_d   = S_RUN;
                            mode_d    = MODE_RUN;
                            mosi_d    = '0;
                            run_cnt_d = '0;
                        end else begin
                            present    = 1'b1;
                            nxt_word   = rd_data_q;
                            bit_cnt_d  = '0;
                            word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
                            rd_addr_d  = rd_addr_q + ADDR_W'(1);
                        end
                    end else begin
                        present   = 1'b1;
                        nxt_word  = shift_q << LANES;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (done_rise || run_cnt_q == TO_MAX) begin
                    state_d    = done_rise ? S_IDLE : S_ERR;
                    finished_d = done_rise;
                    error_d    = !done_rise;
                    busy_d     = 1'b0;
                    mode_d     = MODE_IDLE;
                    mosi_d     = '0;
                    rst_n_d    = 1'b0;
                    sclk_d     = 1'b0;
                    div_cnt_d  = '0;
                end else begin
                    run_cnt_d = run_cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (present) begin
            shift_d = nxt_word;
            mosi_d  = nxt_word[DATA_W-1 -: LANES];
`ifdef PROG_LOADER_CRC_EN
            crc_d   = crc8_step(crc_q, nxt_word[DATA_W-1 -: LANES]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            error_q     <= 1'b0;
            sclk_q      <= 1'b0;
            rst_n_q     <= 1'b0;
            mosi_q      <= '0;
            mode_q      <= MODE_IDLE;
            div_cnt_q   <= '0;
            rst_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            len_q       <= '0;
            rd_addr_q   <= '0;
            run_cnt_q   <= '0;
            done_sync_q <= '0;
`ifdef PROG_LOADER_CRC_EN
            crc_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            error_q     <= error_d;
            sclk_q      <= sclk_d;
            rst_n_q     <= rst_n_d;
            mosi_q      <= mosi_d;
            mode_q      <= mode_d;
            div_cnt_q   <= div_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            rd_addr_q   <= rd_addr_d;
            run_cnt_q   <= run_cnt_d;
            done_sync_q <= {done_sync_q[1:0], done_in};
`ifdef PROG_LOADER_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

    // Program RAM and word shifter carry data only; they survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr_q];
        shift_q   <= shift_d;
    end

    assign busy      = busy_q;
    assign finished  = finished_q;
    assign error     = error_q;
    assign sclk_out  = sclk_q;
    assign rst_n_out = rst_n_q;
    assign mosi_out  = mosi_q;
    assign mode_out  = mode_q;
`ifdef PROG_LOADER_CRC_EN
    assign crc_out   = crc_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected mosi bits are queued at start and popped on rising sclk.
module tb_prog_loader;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int TO  = 200;
    localparam int AW4 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en = 0, start = 0, done_in = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   len_in = '0;
    logic          busy, finished, error, sclk_out, rst_n_out;
    logic [0:0]    mosi_out;
    logic [1:0]    mode_out;

    logic           wr_en4 = 0, start4 = 0, done_in4 = 0;
    logic [AW4-1:0] wr_addr4 = '0;
    logic [DW-1:0]  wr_data4 = '0;
    logic [AW4:0]   len_in4 = '0;
    logic           busy4, finished4, error4, sclk4, rst_n4;
    logic [3:0]     mosi4;
    logic [1:0]     mode4;
`ifdef PROG_LOADER_CRC_EN
    logic [7:0]     crc_out, crc4;
`endif

    prog_loader #(.DATA_W(DW), .DEPTH(DEP), .LANES(1), .CLK_DIV(2), .RST_CYC(4), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_in(len_in), .start(start), .busy(busy), .finished(finished), .error(error),
        .sclk_out(sclk_out), .rst_n_out(rst_n_out), .mosi_out(mosi_out), .mode_out(mode_out),
        .done_in(done_in)
`ifdef PROG_LOADER_CRC_EN
        , .crc_out(crc_out)
`endif
    );

    prog_loader #(.DATA_W(DW), .DEPTH(4), .LANES(4), .CLK_DIV(1), .RST_CYC(2), .TIMEOUT(32)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .len_in(len_in4), .start(start4), .busy(busy4), .finished(finished4), .error(error4),
        .sclk_out(sclk4), .rst_n_out(rst_n4), .mosi_out(mosi4), .mode_out(mode4),
        .done_in(done_in4)
`ifdef PROG_LOADER_CRC_EN
        , .crc_out(crc4)
`endif
    );

    int n_cmp = 0, n_bad = 0;
    int n_trst = 0, n_load = 0, n_run = 0, n_load4 = 0;
    logic prev_sclk = 1'b0, prev_sclk4 = 1'b0;
    bit        sb[$];
    bit [3:0]  sb4[$];
    logic [7:0] model [DEP];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clk cycle; samples on the falling clk edge and pops the scoreboards on rising sclk
    task automatic tick();
        @(negedge clk);
        if (sclk_out && !prev_sclk) begin
            if (mode_out == 2'b01) begin
                n_load++;
                if (sb.size() == 0) chk("sb_underrun", 32'(sb.size()), 32'd1);
                else chk("mosi_bit", 32'(mosi_out), 32'(sb.pop_front()));
            end else if (mode_out == 2'b00 && busy) begin
                n_trst++;
            end
        end
        prev_sclk = sclk_out;
        if (mode_out == 2'b10) n_run++;
        if (sclk4 && !prev_sclk4 && mode4 == 2'b01) begin
            n_load4++;
            if (sb4.size() == 0) chk("sb4_underrun", 32'(sb4.size()), 32'd1);
            else chk("mosi4_nibble", 32'(mosi4), 32'(sb4.pop_front()));
        end
        prev_sclk4 = sclk4;
    endtask

    task automatic wr(input int a, input logic [7:0] d, input bit taken);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        if (taken) model[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go(input int len);
        int n;
        n = (len > DEP) ? DEP : len;
        for (int w = 0; w < n; w++)
            for (int b = DW - 1; b >= 0; b--) sb.push_back(model[w][b]);
        len_in = (AW + 1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_mode(input logic [1:0] m, input int budget, input string tag);
        int k = 0;
        while (mode_out !== m && k < budget) begin tick(); k++; end
        if (mode_out !== m) chk(tag, 32'(mode_out), 32'(m));
    endtask

    task automatic finish_run();
        int first = -1, cnt = 0;
        done_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (finished) begin cnt++; if (first < 0) first = i; end
        end
        chk("fin_pulses", 32'(cnt), 32'd1);
        chk("fin_within_3", 32'(first >= 1 && first <= 3), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("mode_after_done", 32'(mode_out), 32'd0);
        done_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_finished"}, 32'(finished), 32'd0);
        chk({pfx, "_error"}, 32'(error), 32'd0);
        chk({pfx, "_sclk"}, 32'(sclk_out), 32'd0);
        chk({pfx, "_rst_n"}, 32'(rst_n_out), 32'd0);
        chk({pfx, "_mosi"}, 32'(mosi_out), 32'd0);
        chk({pfx, "_mode"}, 32'(mode_out), 32'd0);
    endtask

    initial begin
        int tb0, lb0, rb0, k;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Two-word image, 1 lane
        wr(0, 8'hA5, 1);
        wr(1, 8'h3C, 1);
        tb0 = n_trst; lb0 = n_load;
        go(2);
        wait_mode(2'b10, 400, "to_run_A");
        chk("trst_periods", 32'(n_trst - tb0), 32'd4);
        chk("load_periods_A", 32'(n_load - lb0), 32'd16);
        chk("sb_empty_A", 32'(sb.size()), 32'd0);
        chk("rst_n_in_run", 32'(rst_n_out), 32'd1);
        finish_run();

        // Timeout path, then len=0 start clears the sticky error
        rb0 = n_run;
        go(1);
        wait_mode(2'b10, 400, "to_run_T");
        k = 0;
        while (!error && k < TO + 100) begin tick(); k++; end
        chk("err_set", 32'(error), 32'd1);
        chk("run_cycles", 32'(n_run - rb0), 32'(TO));
        chk("busy_in_err", 32'(busy), 32'd0);
        chk("rst_n_in_err", 32'(rst_n_out), 32'd0);
        chk("mode_in_err", 32'(mode_out), 32'd0);
        tick();
        chk("err_sticky", 32'(error), 32'd1);
        tb0 = n_trst; lb0 = n_load;
        go(0);
        chk("err_cleared", 32'(error), 32'd0);
        chk("busy_on_start", 32'(busy), 32'd1);
        wait_mode(2'b10, 400, "to_run_len0");
        chk("load_periods_len0", 32'(n_load - lb0), 32'd0);
        chk("trst_periods_len0", 32'(n_trst - tb0), 32'd4);
        finish_run();

        // Write and start while busy are both dropped
        lb0 = n_load;
        go(2);
        repeat (30) tick();
        chk("mid_load_mode", 32'(mode_out), 32'd1);
        wr(0, 8'hFF, 0);
        start = 1'b1; tick(); start = 1'b0;
        wait_mode(2'b10, 400, "to_run_B");
        chk("load_periods_B", 32'(n_load - lb0), 32'd16);
        chk("sb_empty_B", 32'(sb.size()), 32'd0);
        finish_run();

        // len above DEPTH is clamped; word 0 must still be 0xA5
        for (int i = 1; i < DEP; i++) wr(i, 8'((i * 37 + 11) & 8'hFF), 1);
        lb0 = n_load;
        go(DEP + 5);
        wait_mode(2'b10, 800, "to_run_C");
        chk("load_periods_clamp", 32'(n_load - lb0), 32'(DEP * DW));
        chk("sb_empty_C", 32'(sb.size()), 32'd0);
        finish_run();

        // Reset in the middle of LOAD
        go(DEP);
        repeat (40) tick();
        chk("pre_rst_mode", 32'(mode_out), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        rst = 1'b0;
        sb.delete();
        tick();

        // Four lanes: 0x5A goes out as 0x5 then 0xA
        wr_en4 = 1'b1; wr_addr4 = '0; wr_data4 = 8'h5A;
        tick();
        wr_en4 = 1'b0;
        sb4.push_back(4'h5);
        sb4.push_back(4'hA);
        lb0 = n_load4;
        len_in4 = 3'd1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        k = 0;
        while (mode4 !== 2'b10 && k < 100) begin tick(); k++; end
        chk("lanes4_run", 32'(mode4), 32'd2);
        chk("lanes4_periods", 32'(n_load4 - lb0), 32'd2);
        chk("sb4_empty", 32'(sb4.size()), 32'd0);
        k = 0;
        while (!error4 && k < 100) begin tick(); k++; end
        chk("lanes4_timeout", 32'(error4), 32'd1);

`ifdef PROG_LOADER_CRC_EN
        wr(0, 8'h01, 1);
        go(1);
        wait_mode(2'b10, 400, "to_run_crc");
        chk("crc_0x01", 32'(crc_out), 32'h07);
        finish_run();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
